// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: step-mode and FSM state encodings
// plus default geometry.
package shift_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 4;

  // One-step operation applied to the register on every step edge.
  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SLL  = 3'b001,
    MODE_SRL  = 3'b010,
    MODE_SRA  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_SIL  = 3'b110,
    MODE_SIR  = 3'b111
  } mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage : shift_sequencer_pkg

// File: rtl/shift_sequencer_step.sv
// Combinational single-step datapath: the next register value and the bit it
// expels, for one shift/rotate step of the selected mode.
module shift_step_logic
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic             sin,
  output logic [WIDTH-1:0] q_next,
  output logic             sout_next
);

  // Select the shifted word and the expelled bit for the requested mode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    q_next    = q;
    sout_next = 1'b0;
    unique case (mode)
      MODE_HOLD: begin
        q_next    = q;
        sout_next = 1'b0;
      end
      MODE_SLL: begin
        q_next    = {q[WIDTH-2:0], 1'b0};
        sout_next = q[WIDTH-1];
      end
      MODE_SRL: begin
        q_next    = {1'b0, q[WIDTH-1:1]};
        sout_next = q[0];
      end
      MODE_SRA: begin
        q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
        sout_next = q[0];
      end
      MODE_ROL: begin
        q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
        sout_next = q[WIDTH-1];
      end
      MODE_ROR: begin
        q_next    = {q[0], q[WIDTH-1:1]};
        sout_next = q[0];
      end
      MODE_SIL: begin
        q_next    = {q[WIDTH-2:0], sin};
        sout_next = q[WIDTH-1];
      end
      MODE_SIR: begin
        q_next    = {sin, q[WIDTH-1:1]};
        sout_next = q[0];
      end
      default: begin
        q_next    = q;
        sout_next = 1'b0;
      end
    endcase
  end

endmodule : shift_step_logic

// File: rtl/shift_sequencer.sv
// Shift sequencer: parallel load, then a programmed number of one-bit
// shift/rotate steps (one per clock) with a busy/done handshake.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  mode_t            mode_r, mode_next;
  logic [CNT_W-1:0] cnt_r, cnt_next;
  logic [WIDTH-1:0] q_next;
  logic             sout_next;
  logic             done_next;

  logic [WIDTH-1:0] step_q;
  logic             step_sout;

  shift_step_logic #(
    .WIDTH(WIDTH)
  ) u_step (
    .q        (q),
    .mode     (mode_r),
    .sin      (sin),
    .q_next   (step_q),
    .sout_next(step_sout)
  );

  // State register and datapath registers; clr wipes everything asynchronously.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= ST_IDLE;
      mode_r <= MODE_HOLD;
      cnt_r  <= '0;
      q      <= '0;
      sout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state  <= state_next;
      mode_r <= mode_next;
      cnt_r  <= cnt_next;
      q      <= q_next;
      sout   <= sout_next;
      done   <= done_next;
    end
  end

  // Next-state and datapath selection: load beats start, start beats stepping.
  always_comb begin
    state_next = state;
    mode_next  = mode_r;
    cnt_next   = cnt_r;
    q_next     = q;
    sout_next  = sout;
    done_next  = 1'b0;

    if (load) begin
      // A load aborts any running sequence without a done pulse.
      q_next     = din;
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (amount != '0) begin
              state_next = ST_SHIFT;
              mode_next  = mode_t'(mode);
              cnt_next   = amount;
            end else begin
              // Nothing to do: acknowledge immediately.
              done_next = 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          q_next    = step_q;
          sout_next = step_sout;
          cnt_next  = cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // busy is a direct decode of the state so it follows clr without a clock.
  always_comb begin
    busy = (state == ST_SHIFT);
  end

endmodule : shift_sequencer

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-bit shift register built on the single-bit storage cell the team already has.
- Consumes a parallel word, then performs a programmed number of one-bit shift or rotate steps, one per clock.
- Reports progress with a busy/done handshake.
- Feeds the downstream serial/parallel consumers in the register-and-memory experiment chain, through the q parallel output and the sout serial output.

Parameters:
- WIDTH, 8, data word width in bits (must be ≥2).
- CNT_W, 4, width of the shift-amount field; amounts 0 .. 2^CNT_W-1 are legal.

Ports:
- clk  in  1  single clock; all state changes on its rising edge except reset.
- clr  in  1  asynchronous, active-high reset.
- load  in  1  synchronous parallel load of din.
- din  in  WIDTH  parallel load data.
- start  in  1  begin a shift sequence (sampled in IDLE only).
- mode  in  3  shift operation, latched at start.
- amount  in  CNT_W  number of steps, latched at start.
- sin  in  1  serial input for the serial-in modes, sampled on every step.
- q  out  WIDTH  register contents.
- sout  out  1  bit expelled by the most recent step.
- busy  out  1  high while steps remain.
- done  out  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset: clr=1 forces q=0, sout=0, busy=0, done=0, state=IDLE immediately, without waiting for clk. It also clears the latched mode and count. Reset mid-sequence abandons the sequence; no done pulse follows.
- Priority at each rising edge: clr > load > start > stepping.
- Load: load=1 sets q<=din in any state. If busy, the sequence is aborted: state=IDLE, busy=0, no done pulse. sout is unchanged.
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1, remaining count > 0.
- IDLE → SHIFT: on an edge with start=1, load=0, amount=N>0. The edge latches mode and N; q is not modified on that edge. busy is high from that edge onward.
- SHIFT steps: each subsequent edge performs one step and decrements the count. The edge performing step N returns to IDLE, clears busy and sets done=1 for exactly one cycle. q reaches its final value N edges after the start edge.
- Zero amount: start with amount=0 stays in IDLE, leaves q unchanged and pulses done on the following cycle.
- Ignored inputs: start while busy is ignored. mode and amount changes while busy are ignored.
- Mode encodings (one step each):
  - 000 HOLD: q unchanged, sout=0.
  - 001 SLL: q<={q[W-2:0],0}, sout=q[W-1].
  - 010 SRL: q<={0,q[W-1:1]}, sout=q[0].
  - 011 SRA: q<={q[W-1],q[W-1:1]}, sout=q[0].
  - 100 ROL: q<={q[W-2:0],q[W-1]}, sout=q[W-1].
  - 101 ROR: q<={q[0],q[W-1:1]}, sout=q[0].
  - 110 SIL: q<={q[W-2:0],sin}, sout=q[W-1].
  - 111 SIR: q<={sin,q[W-1:1]}, sout=q[0].
- Over-length amounts: amount>WIDTH is legal. Logical shifts saturate to 0, SRA to all-sign-bits, and rotates wrap naturally.
- sout holds its value between steps and across IDLE.

Decomposition:
- Shared package: mode encodings (MODE_HOLD..MODE_SIR), state encoding (ST_IDLE, ST_SHIFT), default WIDTH/CNT_W.
- One sub-module, shift_step_logic: combinational next-q and next-sout for one step given q, mode and sin. It is instanced once; the sequencer owns all registers.

Test Plan:
- Arithmetic shift: load 0x96, start mode=011 amount=3 → busy high for 3 cycles, q=0xF2, sout=1, done pulses once on the cycle after the third step.
- Rotate: load 0x96, mode=100 amount=3 → q=0xB4, sout=0. Then mode=101 amount=3 → q=0x96.
- Serial in: load 0x00, mode=110 amount=4, sin stream 1,0,1,1 → q sequence 0x01, 0x02, 0x05, 0x0B; done after the fourth step.
- Boundaries:
  - load 0xFF, mode=001 amount=9 → q=0x00 after 9 steps.
  - amount=0 → q unchanged, busy never rises, done pulses once.
- Async reset and load abort:
  - clr asserted between edges during step 2 of 5 → q=0, busy=0 before the next edge; no done pulse afterwards.
  - Separately, load 0x3C during busy → q=0x3C, busy=0, no done pulse.
